iic_trig_ctrl: RTL and testbench

Command front-end for the I2C EEPROM master. Debounces two raw push-buttons (write, read) and converts each press into one active-low trigger pulse on the master's `wr_trig`/`rd_trig` inputs. Tracks the transaction through the master's `busy`/`ack_error` outputs, with a timeout. Keeps pass/fail status and saturating success/error counters for LEDs or debug.

---
 rtl/iic_trig_ctrl.sv | 160 ++++++++++++++++
 tb/tb_iic_trig_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_trig_ctrl.sv
// Push-button front-end for the I2C EEPROM master: debounces the write/read keys,
// fires one active-low trigger per press and tracks the transaction to completion.
module iic_trig_ctrl #(
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int TRIG_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = 8
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             key_wr_n,
    input  logic             key_rd_n,
    input  logic             busy,
    input  logic             ack_error,
    output logic             wr_trig,
    output logic             rd_trig,
    output logic             cmd_active,
    output logic             done_pulse,
    output logic             err_flag,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    // Bit 0 is the write key, bit 1 the read key.
    logic [1:0]            key_raw;
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            deb_prev;
    logic [1:0]            deb_state;
    logic [1:0]            deb_state_d;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [1:0]            press_evt;

    state_t                state;
    logic [TRIG_W-1:0]     trig_cnt;
    logic [TO_W-1:0]       to_cnt;

    assign key_raw   = {key_rd_n, key_wr_n};
    assign press_evt = deb_state_d & ~deb_state;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync1       <= '1;
            sync2       <= '1;
            deb_prev    <= '1;
            deb_state   <= '1;
            deb_state_d <= '1;
            deb_cnt     <= '0;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            deb_prev    <= sync2;
            deb_state_d <= deb_state;
            // Any movement of the synced level restarts the stability window.
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] != deb_prev[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
                    if (sync2[k] != deb_state[k]) begin
                        deb_state[k] <= sync2[k];
                    end
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            trig_cnt     <= '0;
            to_cnt       <= '0;
            wr_trig      <= 1'b1;
            rd_trig      <= 1'b1;
            cmd_active   <= 1'b0;
            done_pulse   <= 1'b0;
            err_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            ok_cnt       <= '0;
            err_cnt      <= '0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    // Write wins a tie; the trigger registers themselves hold the chosen op.
                    if (press_evt[0] || press_evt[1]) begin
                        wr_trig      <= ~press_evt[0];
                        rd_trig      <= press_evt[0];
                        trig_cnt     <= '0;
                        err_flag     <= 1'b0;
                        timeout_flag <= 1'b0;
                        cmd_active   <= 1'b1;
                        state        <= TRIG;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) begin
                        wr_trig <= 1'b1;
                        rd_trig <= 1'b1;
                        to_cnt  <= '0;
                        state   <= WAIT_BUSY;
                    end else begin
                        trig_cnt <= trig_cnt + TRIG_W'(1);
                    end
                end
                WAIT_BUSY: begin
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if (busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // ack_error is still valid while the master sits in STOP.
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else if (!busy) begin
                        err_flag <= ack_error;
                        state    <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    done_pulse <= 1'b1;
                    cmd_active <= 1'b0;
                    if (err_flag || timeout_flag) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end else if (ok_cnt != '1) begin
                        ok_cnt <= ok_cnt + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_trig_ctrl.sv
// Directed bench for iic_trig_ctrl with short debounce/timeout parameters and a
// hand-driven master model on busy/ack_error.
module tb_iic_trig_ctrl;

    logic       clk_50M;
    logic       rst;
    logic       key_wr_n;
    logic       key_rd_n;
    logic       busy;
    logic       ack_error;
    logic       wr_trig;
    logic       rd_trig;
    logic       cmd_active;
    logic       done_pulse;
    logic       err_flag;
    logic       timeout_flag;
    logic [1:0] ok_cnt;
    logic [1:0] err_cnt;

    int num_checks = 0;
    int num_errors = 0;
    int wr_pulses  = 0;
    int rd_pulses  = 0;
    logic wr_prev  = 1'b1;
    logic rd_prev  = 1'b1;
    int wr_base;
    int rd_base;
    int width;

    iic_trig_ctrl #(
        .DEB_CYCLES    (8),
        .TRIG_CYCLES   (4),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (2)
    ) dut (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .key_wr_n    (key_wr_n),
        .key_rd_n    (key_rd_n),
        .busy        (busy),
        .ack_error   (ack_error),
        .wr_trig     (wr_trig),
        .rd_trig     (rd_trig),
        .cmd_active  (cmd_active),
        .done_pulse  (done_pulse),
        .err_flag    (err_flag),
        .timeout_flag(timeout_flag),
        .ok_cnt      (ok_cnt),
        .err_cnt     (err_cnt)
    );

    initial begin
        clk_50M = 1'b0;
        forever #5 clk_50M = ~clk_50M;
    end

    // Count falling edges of each trigger, sampled away from the active edge.
    always @(negedge clk_50M) begin
        if (wr_prev && !wr_trig) wr_pulses++;
        if (rd_prev && !rd_trig) rd_pulses++;
        wr_prev = wr_trig;
        rd_prev = rd_trig;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr_k, input logic rd_k);
        key_wr_n = wr_k;
        key_rd_n = rd_k;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic waitTrig(input bit use_rd, input int limit);
        int n = 0;
        while (((use_rd ? rd_trig : wr_trig) !== 1'b0) && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        checkOutput("trig_start", 32'(use_rd ? rd_trig : wr_trig), 0);
    endtask

    task automatic measureLow(input bit use_rd, output int w);
        w = 0;
        while (((use_rd ? rd_trig : wr_trig) === 1'b0) && w < 20) begin
            @(negedge clk_50M);
            w++;
        end
    endtask

    // Press keys, expect a 4-cycle pulse on one trigger, then release both keys.
    task automatic pressAndTrig(input logic wr_k, input logic rd_k, input bit exp_rd);
        int w;
        applyStimulus(wr_k, rd_k);
        waitTrig(exp_rd, 40);
        checkOutput("other_trig", 32'(exp_rd ? wr_trig : rd_trig), 1);
        checkOutput("active_trig", 32'(cmd_active), 1);
        checkOutput("flags_clr", 32'({err_flag, timeout_flag}), 0);
        measureLow(exp_rd, w);
        checkOutput("trig_width", w, 4);
        applyStimulus(1'b1, 1'b1);
    endtask

    // Master model: raise busy after 'rise' cycles, hold 'blen' cycles, drop with ack_error=nack.
    task automatic runMaster(input int rise, input int blen, input bit nack, input bit poke_rd,
                             input int exp_ok, input int exp_err);
        repeat (rise) @(negedge clk_50M);
        busy = 1'b1;
        if (poke_rd) begin
            applyStimulus(1'b1, 1'b0);
            waitCycles(15);
            applyStimulus(1'b1, 1'b1);
            waitCycles(blen - 15);
        end else begin
            waitCycles(blen);
        end
        busy      = 1'b0;
        ack_error = nack;
        @(negedge clk_50M);
        checkOutput("err_flag_m1", 32'(err_flag), 32'(nack));
        checkOutput("done_early", 32'(done_pulse), 0);
        checkOutput("active_m1", 32'(cmd_active), 1);
        ack_error = 1'b0;
        @(negedge clk_50M);
        checkOutput("done_pulse", 32'(done_pulse), 1);
        checkOutput("active_m2", 32'(cmd_active), 0);
        checkOutput("ok_cnt", 32'(ok_cnt), exp_ok);
        checkOutput("err_cnt", 32'(err_cnt), exp_err);
        checkOutput("timeout_flag", 32'(timeout_flag), 0);
        @(negedge clk_50M);
        checkOutput("done_clr", 32'(done_pulse), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_wr_trig"}, 32'(wr_trig), 1);
        checkOutput({tag, "_rd_trig"}, 32'(rd_trig), 1);
        checkOutput({tag, "_active"}, 32'(cmd_active), 0);
        checkOutput({tag, "_done"}, 32'(done_pulse), 0);
        checkOutput({tag, "_flags"}, 32'({err_flag, timeout_flag}), 0);
        checkOutput({tag, "_ok_cnt"}, 32'(ok_cnt), 0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    initial begin
        rst = 1'b1;
        busy = 1'b0;
        ack_error = 1'b0;
        applyStimulus(1'b1, 1'b1);
        #12;
        checkResetState("rst0");
        @(negedge clk_50M);
        rst = 1'b0;
        waitCycles(20);

        // Bouncing write key: no event while bouncing, one pulse 11 cycles after the last edge.
        wr_base = wr_pulses;
        for (int i = 0; i < 10; i++) begin
            key_wr_n = ~key_wr_n;
            waitCycles(3);
        end
        checkOutput("bounce_quiet", wr_pulses - wr_base, 0);
        applyStimulus(1'b0, 1'b1);
        waitCycles(11);
        checkOutput("deb_not_yet", 32'(wr_trig), 1);
        @(negedge clk_50M);
        checkOutput("deb_trig_low", 32'(wr_trig), 0);
        checkOutput("deb_rd_idle", 32'(rd_trig), 1);
        checkOutput("deb_active", 32'(cmd_active), 1);
        measureLow(1'b0, width);
        checkOutput("deb_width", width, 4);
        applyStimulus(1'b1, 1'b1);
        // busy held short enough that the 64-cycle timeout cannot fire.
        runMaster(10, 40, 1'b0, 1'b0, 1, 0);
        waitCycles(30);
        checkOutput("wr_pulse_once", wr_pulses - wr_base, 1);
        checkOutput("release_idle", 32'(cmd_active), 0);

        // Read with NACK.
        wr_base = wr_pulses;
        rd_base = rd_pulses;
        pressAndTrig(1'b1, 1'b0, 1'b1);
        runMaster(10, 40, 1'b1, 1'b0, 1, 1);
        waitCycles(20);
        checkOutput("nack_rd_pulses", rd_pulses - rd_base, 1);
        checkOutput("nack_wr_pulses", wr_pulses - wr_base, 0);

        // Timeout: busy never rises.
        pressAndTrig(1'b0, 1'b1, 1'b0);
        waitCycles(63);
        checkOutput("to_not_yet", 32'(timeout_flag), 0);
        checkOutput("to_active", 32'(cmd_active), 1);
        @(negedge clk_50M);
        checkOutput("to_flag", 32'(timeout_flag), 1);
        @(negedge clk_50M);
        checkOutput("to_done", 32'(done_pulse), 1);
        checkOutput("to_err_cnt", 32'(err_cnt), 2);
        checkOutput("to_ok_cnt", 32'(ok_cnt), 1);
        checkOutput("to_idle", 32'(cmd_active), 0);
        waitCycles(20);

        // Both keys together, then a read press during WAIT_DONE.
        wr_base = wr_pulses;
        rd_base = rd_pulses;
        pressAndTrig(1'b0, 1'b0, 1'b0);
        runMaster(15, 40, 1'b0, 1'b1, 2, 2);
        waitCycles(30);
        checkOutput("prio_wr_pulses", wr_pulses - wr_base, 1);
        checkOutput("prio_rd_pulses", rd_pulses - rd_base, 0);
        checkOutput("prio_idle", 32'(cmd_active), 0);

        // Three more good writes take ok_cnt to 5 attempts, saturating at 3.
        for (int n = 3; n <= 5; n++) begin
            pressAndTrig(1'b0, 1'b1, 1'b0);
            runMaster(5, 20, 1'b0, 1'b0, (n > 3) ? 3 : n, 2);
            waitCycles(15);
        end
        checkOutput("sat_ok_cnt", 32'(ok_cnt), 3);

        // Asynchronous reset in the middle of a trigger pulse.
        applyStimulus(1'b0, 1'b1);
        waitTrig(1'b0, 40);
        #2;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        #1;
        checkResetState("rst_mid");
        waitCycles(3);
        rst = 1'b0;
        waitCycles(20);
        checkOutput("post_rst_quiet", 32'(wr_trig), 1);
        checkOutput("post_rst_idle", 32'(cmd_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
